// File: rtl/window3x3_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : window3x3_gen_pkg
// Brief    : Shared constants for the 3x3 window generator and the 3x3 MAC
//            that consumes its windows (default pixel width, tap count and
//            the row-major slot numbering of the window).
// Revision : 1.0 - initial release
// ============================================================================
package window3x3_gen_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int WIN_TAPS   = 9;

  // Row-major slot numbering: top row 0..2, middle row 3..5, bottom row 6..8
  localparam int SLOT_TL = 0;
  localparam int SLOT_TC = 1;
  localparam int SLOT_TR = 2;
  localparam int SLOT_ML = 3;
  localparam int SLOT_MC = 4;
  localparam int SLOT_MR = 5;
  localparam int SLOT_BL = 6;
  localparam int SLOT_BC = 7;
  localparam int SLOT_BR = 8;

  // Slot index of window row r (0 = top), column c (0 = left)
  function automatic int slot_idx(input int r, input int c);
    return r * 3 + c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/window3x3_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : window3x3_gen_if
// Brief    : Pixel-in / window-out stream bundle. The slave modport is the
//            window generator; the master modport is the environment that
//            feeds pixels and drains windows.
// Revision : 1.0 - initial release
// ============================================================================
interface window3x3_gen_if
  import window3x3_gen_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic [DATA_W-1:0]          pix_in;
  logic                       in_valid;
  logic                       in_ready;
  logic [WIN_TAPS*DATA_W-1:0] win_out;
  logic                       out_valid;
  logic                       out_ready;
  logic                       frame_end;

  modport master (
    output pix_in, in_valid, out_ready,
    input  in_ready, win_out, out_valid, frame_end
  );

  modport slave (
    input  pix_in, in_valid, out_ready,
    output in_ready, win_out, out_valid, frame_end
  );

endinterface
`default_nettype wire

// File: rtl/window3x3_gen_row_delay_buf.sv
`default_nettype none
// ============================================================================
// Module   : row_delay_buf
// Brief    : One image row of pixel storage. Read is combinational from the
//            addressed entry, write lands at the same address on the clock
//            edge, so a read and write in the same cycle returns the old
//            value (one row of delay). Contents are never reset: the window
//            generator's row/column gating keeps stale data from escaping.
// Revision : 1.0 - initial release
// ============================================================================
module row_delay_buf #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  // Overwrite the addressed entry with this row's pixel
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/window3x3_gen.sv
`default_nettype none
// ============================================================================
// Module   : window3x3_gen
// Brief    : Streaming 3x3 window generator. Accepts a raster pixel stream,
//            keeps two previous rows in row delay buffers and a 3x3 shift
//            register, and emits one window per accepted pixel whose window
//            lies fully inside the frame (no padding). Single output register
//            stage with ready/valid backpressure, one cycle of latency.
// Revision : 1.0 - initial release
// ============================================================================
module window3x3_gen
  import window3x3_gen_pkg::*;
#(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic            clk,
  input  logic            rst,    // asynchronous, active low
  window3x3_gen_if.slave  bus
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int WB = WIN_TAPS * DATA_W;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [WB-1:0]     win_q, win_d;
  logic [WB-1:0]     out_win_q;
  logic              out_valid_q;
  logic              frame_end_q;
  logic [DATA_W-1:0] a_rd;
  logic [DATA_W-1:0] b_rd;
  logic              accept;
  logic              emit;
  logic              last_pix;

  // Output stage can take a new window when empty or being drained this cycle
  assign bus.in_ready  = bus.out_ready | ~out_valid_q;
  assign accept        = bus.in_valid & bus.in_ready;
  assign emit          = accept & (row_q >= RW'(2)) & (col_q >= CW'(2));
  assign last_pix      = (col_q == COL_LAST) & (row_q == ROW_LAST);

  assign bus.win_out   = out_win_q;
  assign bus.out_valid = out_valid_q;
  assign bus.frame_end = frame_end_q;

  // Buffer A: previous row. Its old entry moves on into buffer B.
  row_delay_buf #(
    .DEPTH  (IMG_W),
    .DATA_W (DATA_W),
    .AW     (CW)
  ) u_buf_a (
    .clk     (clk),
    .we_i    (accept),
    .addr_i  (col_q),
    .wdata_i (bus.pix_in),
    .rdata_o (a_rd)
  );

  // Buffer B: the row before the previous one
  row_delay_buf #(
    .DEPTH  (IMG_W),
    .DATA_W (DATA_W),
    .AW     (CW)
  ) u_buf_b (
    .clk     (clk),
    .we_i    (accept),
    .addr_i  (col_q),
    .wdata_i (a_rd),
    .rdata_o (b_rd)
  );

  // Raster position following the pixel accepted this cycle
  always_comb begin
    col_d = col_q + CW'(1);
    row_d = row_q;
    if (col_q == COL_LAST) begin
      col_d = '0;
      row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
    end
  end

  // Window shifted one column left with the new right column appended
  always_comb begin
    win_d = win_q;
    win_d[SLOT_TL*DATA_W +: DATA_W] = win_q[SLOT_TC*DATA_W +: DATA_W];
    win_d[SLOT_TC*DATA_W +: DATA_W] = win_q[SLOT_TR*DATA_W +: DATA_W];
    win_d[SLOT_TR*DATA_W +: DATA_W] = b_rd;
    win_d[SLOT_ML*DATA_W +: DATA_W] = win_q[SLOT_MC*DATA_W +: DATA_W];
    win_d[SLOT_MC*DATA_W +: DATA_W] = win_q[SLOT_MR*DATA_W +: DATA_W];
    win_d[SLOT_MR*DATA_W +: DATA_W] = a_rd;
    win_d[SLOT_BL*DATA_W +: DATA_W] = win_q[SLOT_BC*DATA_W +: DATA_W];
    win_d[SLOT_BC*DATA_W +: DATA_W] = win_q[SLOT_BR*DATA_W +: DATA_W];
    win_d[SLOT_BR*DATA_W +: DATA_W] = bus.pix_in;
  end

  // Position counters, shift register, output stage and frame-end pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q       <= '0;
      row_q       <= '0;
      win_q       <= '0;
      out_win_q   <= '0;
      out_valid_q <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      frame_end_q <= accept & last_pix;
      if (accept) begin
        col_q <= col_d;
        row_q <= row_d;
        win_q <= win_d;
      end
      if (emit) begin
        out_win_q   <= win_d;
        out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_window3x3_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_window3x3_gen
// Brief    : Self-checking bench for window3x3_gen on a 4x4 image. Expected
//            windows are computed from the pixel numbering and queued as
//            pixels are accepted; a monitor pops and compares on every
//            output transfer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_window3x3_gen;
  import window3x3_gen_pkg::*;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int DW = 8;
  localparam int WB = WIN_TAPS * DW;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int n_win    = 0;
  int n_fe     = 0;

  logic [WB-1:0] exp_q [$];

  window3x3_gen_if #(.DATA_W(DW)) bus ();

  window3x3_gen #(
    .IMG_W  (W),
    .IMG_H  (H),
    .DATA_W (DW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WB-1:0] got, input logic [WB-1:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Window whose bottom-right is frame pixel (r, c); pixel value = base + r*W + c + 1
  function automatic logic [WB-1:0] exp_win(input int base, input int r, input int c);
    logic [WB-1:0] w;
    w = '0;
    for (int wr = 0; wr < 3; wr++) begin
      for (int wc = 0; wc < 3; wc++) begin
        w[slot_idx(wr, wc)*DW +: DW] = DW'(base + (r - 2 + wr) * W + (c - 2 + wc) + 1);
      end
    end
    return w;
  endfunction

  // Output monitor: every transfer must match the oldest expected window
  always @(negedge clk) begin
    if (rst && bus.out_valid && bus.out_ready) begin
      chk("sb_window_expected", WB'(exp_q.size() != 0), WB'(1));
      if (exp_q.size() != 0) begin
        chk("sb_window", bus.win_out, exp_q.pop_front());
      end
      n_win++;
    end
    if (rst && bus.frame_end) n_fe++;
  end

  // Drive one pixel (frame index p) until accepted, then check the cycle after
  task automatic send_pix(input int base, input int p);
    int r;
    int c;
    int guard;
    r = p / W;
    c = p % W;
    guard = 0;
    bus.pix_in   = DW'(base + p + 1);
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    chk("accept_timeout", WB'(bus.in_ready), WB'(1));
    if (r >= 2 && c >= 2) exp_q.push_back(exp_win(base, r, c));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("out_valid_latency", WB'(bus.out_valid), WB'(r >= 2 && c >= 2));
    chk("frame_end", WB'(bus.frame_end), WB'(p == W * H - 1));
  endtask

  // Hold the first window of the frame for three cycles with pixel 12 pending
  task automatic do_stall(input int base);
    logic [WB-1:0] hold;
    hold = exp_win(base, 2, 2);
    bus.out_ready = 1'b0;
    bus.pix_in    = DW'(base + 12);
    bus.in_valid  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", WB'(bus.in_ready), WB'(0));
      chk("stall_out_valid", WB'(bus.out_valid), WB'(1));
      chk("stall_hold", bus.win_out, hold);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
  endtask

  task automatic send_frame(input int base, input int npix, input bit rnd, input int stall_at);
    for (int p = 0; p < npix; p++) begin
      if (rnd && $urandom_range(0, 1) == 1) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      if (p == stall_at) do_stall(base);
      send_pix(base, p);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.pix_in    = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    rst           = 1'b0;
    #12;
    chk("reset_out_valid", WB'(bus.out_valid), WB'(0));
    chk("reset_frame_end", WB'(bus.frame_end), WB'(0));
    chk("reset_win_out", bus.win_out, '0);
    chk("reset_in_ready", WB'(bus.in_ready), WB'(1));
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Frame 1..16 with a backpressure stall on the first window
    send_frame(0, 16, 1'b0, 11);
    // Frame 101..116 back to back
    send_frame(100, 16, 1'b0, -1);
    // Partial frame, then reset
    send_frame(0, 7, 1'b0, -1);
    rst = 1'b0;
    #1;
    chk("midreset_out_valid", WB'(bus.out_valid), WB'(0));
    chk("midreset_win_out", bus.win_out, '0);
    chk("midreset_frame_end", WB'(bus.frame_end), WB'(0));
    chk("midreset_in_ready", WB'(bus.in_ready), WB'(1));
    @(posedge clk);
    #1;
    rst = 1'b1;
    send_frame(0, 16, 1'b0, -1);
    // Random input gaps
    send_frame(0, 16, 1'b1, -1);

    repeat (5) @(posedge clk);
    #1;
    chk("sb_drained", WB'(exp_q.size()), WB'(0));
    chk("window_count", WB'(n_win), WB'(16));
    chk("frame_end_count", WB'(n_fe), WB'(4));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
